// File: rtl/song_time_display.sv
// Elapsed-seconds to M:SS BCD converter with a 4-slot multiplexed
// active-low 7-segment driver.
//
// Ports:
//   clk, reset      - system clock, synchronous active-high reset
//   seconds         - elapsed seconds (0-255) from the song timer
//   blank           - 1 darkens all digits; conversion and scan keep running
//   min_bcd         - minutes digit (0-4)
//   sec_tens_bcd    - seconds tens digit (0-5)
//   sec_ones_bcd    - seconds ones digit (0-9)
//   conv_done       - one-cycle pulse on the edge the BCD outputs update
//   seg             - segments {g,f,e,d,c,b,a}, active-low
//   dp              - decimal point, active-low, lit as the M:SS separator
//   an              - digit anodes, active-low, an[0] = rightmost digit
module song_time_display #(
    parameter int unsigned SCAN_DIV = 27000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] seconds,
    input  logic       blank,
    output logic [3:0] min_bcd,
    output logic [3:0] sec_tens_bcd,
    output logic [3:0] sec_ones_bcd,
    output logic       conv_done,
    output logic [6:0] seg,
    output logic       dp,
    output logic [3:0] an
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_DIV60 = 2'd1;
    localparam logic [1:0] S_DIV10 = 2'd2;
    localparam logic [1:0] S_LOAD  = 2'd3;

    localparam logic [19:0] SCAN_LAST = 20'(SCAN_DIV - 1);

    logic [1:0]  state_q, state_d;
    logic [7:0]  rem_q, rem_d;
    logic [2:0]  m_q, m_d;
    logic [2:0]  t_q, t_d;
    logic [7:0]  last_q, last_d;
    logic [3:0]  min_q, min_d;
    logic [3:0]  tens_q, tens_d;
    logic [3:0]  ones_q, ones_d;
    logic        done_q, done_d;

    logic [19:0] cnt_q, cnt_d;
    logic [1:0]  idx_q, idx_d;
    logic [3:0]  an_q, an_d;
    logic [6:0]  seg_q, seg_d;
    logic        dp_q, dp_d;
    logic [3:0]  digit;

    function automatic logic [6:0] seg7(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            default: s = 7'h7F;
        endcase
        return s;
    endfunction

    // Repeated-subtraction divider: minutes by 60, then tens by 10.
    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        m_d     = m_q;
        t_d     = t_q;
        last_d  = last_q;
        min_d   = min_q;
        tens_d  = tens_q;
        ones_d  = ones_q;
        done_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (seconds != last_q) begin
                    rem_d   = seconds;
                    m_d     = 3'd0;
                    last_d  = seconds;
                    state_d = S_DIV60;
                end
            end
            S_DIV60: begin
                if (rem_q >= 8'd60) begin
                    rem_d = rem_q - 8'd60;
                    m_d   = m_q + 3'd1;
                end else begin
                    t_d     = 3'd0;
                    state_d = S_DIV10;
                end
            end
            S_DIV10: begin
                if (rem_q >= 8'd10) begin
                    rem_d = rem_q - 8'd10;
                    t_d   = t_q + 3'd1;
                end else begin
                    state_d = S_LOAD;
                end
            end
            default: begin
                min_d   = {1'b0, m_q};
                tens_d  = {1'b0, t_q};
                ones_d  = rem_q[3:0];
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
        endcase
    end

    // Display registers are loaded from the next index so they switch
    // on the same edge the index advances.
    always_comb begin
        cnt_d = cnt_q + 20'd1;
        idx_d = idx_q;
        if (cnt_q == SCAN_LAST) begin
            cnt_d = '0;
            idx_d = idx_q + 2'd1;
        end
        digit = ones_q;
        an_d  = 4'b1111;
        dp_d  = 1'b1;
        seg_d = 7'h7F;
        case (idx_d)
            2'd0: begin
                an_d  = 4'b1110;
                digit = ones_q;
            end
            2'd1: begin
                an_d  = 4'b1101;
                digit = tens_q;
            end
            2'd2: begin
                an_d  = 4'b1011;
                digit = min_q;
                dp_d  = 1'b0;
            end
            default: ;
        endcase
        if (idx_d != 2'd3) begin
            seg_d = seg7(digit);
        end
        if (blank) begin
            an_d  = 4'b1111;
            seg_d = 7'h7F;
            dp_d  = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            rem_q   <= '0;
            m_q     <= '0;
            t_q     <= '0;
            last_q  <= '0;
            min_q   <= '0;
            tens_q  <= '0;
            ones_q  <= '0;
            done_q  <= 1'b0;
            cnt_q   <= '0;
            idx_q   <= '0;
            an_q    <= 4'b1111;
            seg_q   <= 7'h7F;
            dp_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            m_q     <= m_d;
            t_q     <= t_d;
            last_q  <= last_d;
            min_q   <= min_d;
            tens_q  <= tens_d;
            ones_q  <= ones_d;
            done_q  <= done_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            an_q    <= an_d;
            seg_q   <= seg_d;
            dp_q    <= dp_d;
        end
    end

    assign min_bcd      = min_q;
    assign sec_tens_bcd = tens_q;
    assign sec_ones_bcd = ones_q;
    assign conv_done    = done_q;
    assign seg          = seg_q;
    assign dp           = dp_q;
    assign an           = an_q;

endmodule

// File: tb/tb_song_time_display.sv
// Directed bench for song_time_display: conversion scoreboard,
// latency, scan sequence, blanking and reset checks.
module tb_song_time_display;

    localparam int SD = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] seconds;
    logic       blank;
    logic [3:0] min_bcd;
    logic [3:0] sec_tens_bcd;
    logic [3:0] sec_ones_bcd;
    logic       conv_done;
    logic [6:0] seg;
    logic       dp;
    logic [3:0] an;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    logic [11:0] sb[$];
    logic [3:0]  cm, ct, co;

    logic [6:0] SEGT [10] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
        7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
    };

    song_time_display #(.SCAN_DIV(SD)) dut (
        .clk          (clk),
        .reset        (reset),
        .seconds      (seconds),
        .blank        (blank),
        .min_bcd      (min_bcd),
        .sec_tens_bcd (sec_tens_bcd),
        .sec_ones_bcd (sec_ones_bcd),
        .conv_done    (conv_done),
        .seg          (seg),
        .dp           (dp),
        .an           (an)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (reset) cyc <= 0;
        else       cyc <= cyc + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: every conv_done must match the oldest pushed result.
    always @(negedge clk) begin
        if (!reset && conv_done) begin
            if (sb.size() == 0) begin
                chk("sb_unexpected_done", 32'd1, 32'd0);
            end else begin
                chk("sb_bcd", 32'({min_bcd, sec_tens_bcd, sec_ones_bcd}),
                    32'(sb.pop_front()));
            end
        end
    end

    task automatic wait_done(output int n);
        n = 0;
        for (int i = 1; i <= 30; i++) begin
            @(posedge clk);
            #1;
            if (conv_done) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic chk_bcd(input string tag, input logic [3:0] m,
                           input logic [3:0] t, input logic [3:0] o);
        chk(tag, 32'({min_bcd, sec_tens_bcd, sec_ones_bcd}), 32'({m, t, o}));
    endtask

    task automatic convert(input logic [7:0] v, input int lat,
                           input logic [3:0] m, input logic [3:0] t,
                           input logic [3:0] o);
        int n;
        @(negedge clk);
        seconds = v;
        sb.push_back({m, t, o});
        wait_done(n);
        chk($sformatf("latency_%0d", v), 32'(n - 1), 32'(lat));
        chk_bcd($sformatf("bcd_%0d", v), m, t, o);
        cm = m;
        ct = t;
        co = o;
    endtask

    task automatic scan_check(input int ncyc, input logic bl);
        logic [3:0] ea;
        logic [6:0] es;
        logic       ed;
        int         idx;
        for (int i = 0; i < ncyc; i++) begin
            @(posedge clk);
            #1;
            idx = (cyc / SD) % 4;
            ea  = 4'b1111;
            es  = 7'h7F;
            ed  = 1'b1;
            if (!bl) begin
                case (idx)
                    0: begin ea = 4'b1110; es = SEGT[co]; end
                    1: begin ea = 4'b1101; es = SEGT[ct]; end
                    2: begin ea = 4'b1011; es = SEGT[cm]; ed = 1'b0; end
                    default: ;
                endcase
            end
            chk("scan_an", 32'(an), 32'(ea));
            chk("scan_seg", 32'(seg), 32'(es));
            chk("scan_dp", 32'(dp), 32'(ed));
        end
    endtask

    initial begin
        int n;
        reset   = 1'b1;
        seconds = 8'd0;
        blank   = 1'b0;
        cm = 4'd0;
        ct = 4'd0;
        co = 4'd0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_an", 32'(an), 32'hF);
        chk("rst_seg", 32'(seg), 32'h7F);
        chk("rst_dp", 32'(dp), 32'd1);
        chk("rst_done", 32'(conv_done), 32'd0);
        chk_bcd("rst_bcd", 4'd0, 4'd0, 4'd0);
        @(negedge clk);
        reset = 1'b0;

        scan_check(32, 1'b0);

        convert(8'd75, 5, 4'd1, 4'd1, 4'd5);
        scan_check(16, 1'b0);
        convert(8'd5, 3, 4'd0, 4'd0, 4'd5);
        convert(8'd239, 11, 4'd3, 4'd5, 4'd9);
        scan_check(16, 1'b0);
        convert(8'd255, 8, 4'd4, 4'd1, 4'd5);
        scan_check(16, 1'b0);

        convert(8'd10, 4, 4'd0, 4'd1, 4'd0);
        @(negedge clk);
        seconds = 8'd20;
        sb.push_back(12'h020);
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        seconds = 8'd21;
        sb.push_back(12'h021);
        wait_done(n);
        chk("skip_first_seen", 32'(n != 0), 32'd1);
        chk_bcd("skip_bcd_20", 4'd0, 4'd2, 4'd0);
        wait_done(n);
        chk("skip_second_lat", 32'(n), 32'd6);
        chk_bcd("skip_bcd_21", 4'd0, 4'd2, 4'd1);
        cm = 4'd0;
        ct = 4'd2;
        co = 4'd1;
        scan_check(8, 1'b0);

        @(negedge clk);
        blank = 1'b1;
        scan_check(10, 1'b1);
        @(negedge clk);
        blank = 1'b0;
        scan_check(16, 1'b0);

        @(negedge clk);
        seconds = 8'd200;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        reset   = 1'b1;
        seconds = 8'd0;
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("midrst_an", 32'(an), 32'hF);
        chk("midrst_done", 32'(conv_done), 32'd0);
        chk_bcd("midrst_bcd", 4'd0, 4'd0, 4'd0);
        @(negedge clk);
        reset = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        chk("sb_empty", 32'(sb.size()), 32'd0);
        chk_bcd("final_bcd", 4'd0, 4'd0, 4'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/song_time_display.md
Name: song_time_display

Overview:
Downstream consumer of the song elapsed-time counter. Takes the 8-bit elapsed-seconds value (0-255) and converts it to minutes:seconds BCD with a small iterative divider FSM. Drives a 4-digit, active-low, multiplexed 7-segment display with the result in M:SS form. Also exports the BCD fields for the graphics overlay.

Parameters:
SCAN_DIV, 27000, clk cycles per digit slot (1 kHz digit rate at 27 MHz); legal range 2 to 2^20-1.

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high
seconds  input  8  elapsed seconds from song timer, unsigned
blank  input  1  1 = all digits dark; conversion keeps running
min_bcd  output  4  minutes digit, 0-4
sec_tens_bcd  output  4  seconds tens digit, 0-5
sec_ones_bcd  output  4  seconds ones digit, 0-9
conv_done  output  1  one-cycle pulse when BCD outputs update
seg  output  7  segments {g,f,e,d,c,b,a}, active-low
dp  output  1  decimal point, active-low; used as the M:SS separator
an  output  4  digit anodes, active-low; an[0] = rightmost digit

Behaviour:
- Reset: min_bcd, sec_tens_bcd and sec_ones_bcd = 0. conv_done = 0. last_sec = 0. FSM in IDLE. Scan counter = 0, digit index = 0. an = 4'b1111, seg = 7'h7F, dp = 1.
- Reset mid-conversion: the conversion is abandoned and no conv_done pulse is issued.
- Conversion FSM states: IDLE, DIV60, DIV10, LOAD.
- IDLE: when seconds != last_sec, set rem <= seconds, m <= 0, last_sec <= seconds, and go to DIV60. Otherwise stay in IDLE.
- DIV60, one step per cycle: if rem >= 60, then rem <= rem - 60 and m <= m + 1. Otherwise t <= 0 and go to DIV10.
- DIV10, one step per cycle: if rem >= 10, then rem <= rem - 10 and t <= t + 1. Otherwise go to LOAD.
- LOAD: min_bcd <= m, sec_tens_bcd <= t, sec_ones_bcd <= rem[3:0]. conv_done = 1 for this cycle only. Return to IDLE.
- Latency: with k = seconds/60 and j = (seconds mod 60)/10, outputs change k+j+3 clocks after the capture edge.
  - Minimum latency is 3 clocks, e.g. seconds = 5.
  - Maximum latency is 11 clocks, at seconds = 239.
  - A value of 255 gives 4:15.
- Input changes during DIV60, DIV10 or LOAD are ignored. IDLE compares again on the next cycle, so only the latest value is converted. Intermediate values may be skipped.
- Widths: rem is 8 bits, m is 3 bits (max 4), t is 3 bits (max 5). No overflow is possible for inputs 0-255.
- Scan counter: counts 0..SCAN_DIV-1. On the terminal count it wraps to 0 and the digit index advances 0→1→2→3→0.
- Display outputs are registered and change on the same edge as the digit index.
- Digit assignment:
  - Index 0: an = 1110, shows sec_ones_bcd.
  - Index 1: an = 1101, shows sec_tens_bcd.
  - Index 2: an = 1011, shows min_bcd, dp = 0 as the separator.
  - Index 3: an = 1111 and seg = 7'h7F (slot always dark; keeps duty equal).
- dp = 1 on every slot other than index 2.
- Segment map (gfedcba, active-low):
  - 0 = 1000000, 1 = 1111001, 2 = 0100100, 3 = 0110000, 4 = 0011001
  - 5 = 0010010, 6 = 0000010, 7 = 1111000, 8 = 0000000, 9 = 0010000
  - Any other code = 7'h7F.
- Display always shows the last LOADed BCD values, never partial FSM state.
- blank = 1: an = 1111, seg = 7'h7F, dp = 1 from the next edge. The scan counter and FSM keep running. On release, display resumes at the current digit index.

Test Plan:
- Reset with seconds = 0, SCAN_DIV = 4 → an = 1111 during reset. After release, no conv_done ever fires. The digits cycle with period 16 clks and show 0, 0, 0(dp = 0), dark.
- seconds 0→75 → conv_done exactly 5 clks after the capture edge; min_bcd = 1, sec_tens_bcd = 1, sec_ones_bcd = 5. The index-2 slot shows seg = 1111001 with dp = 0.
- seconds = 239 → min = 3, tens = 5, ones = 9 after 11 clks. seconds = 255 → 4:15 after 8 clks.
- seconds 10→20, then 21 while in DIV10 → one conv_done for 20 (0:20), then a second conv_done for 21 (0:21). No conv_done for intermediate values.
- blank = 1 for 10 clks while scanning → an = 1111 and seg = 7'h7F throughout. After release the digit sequence continues without reset.
- Reset asserted in DIV60 during a 200 conversion → outputs return to 0:00, no conv_done, an = 1111.
